// File: rtl/scmi_mbox_pkg.sv
// Shared types and constants for the multi-channel SCMI mailbox.
// Word offsets are 32-bit word indices within a 256-byte channel window.
package scmi_mbox_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } chan_state_e;

  localparam int unsigned ChanWindowBytes = 256;

  localparam logic [5:0] STATUS       = 6'd0;
  localparam logic [5:0] FLAGS        = 6'd1;
  localparam logic [5:0] LENGTH       = 6'd2;
  localparam logic [5:0] DOORBELL     = 6'd3;
  localparam logic [5:0] COMPLETION   = 6'd4;
  localparam logic [5:0] PAYLOAD_BASE = 6'd8;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } scmi_reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } scmi_reg_rsp_t;

endpackage

// File: rtl/scmi_mbox_channel.sv
// One mailbox channel: FREE/BUSY/DONE protocol FSM, flags, length and payload.
// The parent only asserts wr_en for accesses it has already decoded as valid.
module scmi_mbox_channel
  import scmi_mbox_pkg::*;
#(
  parameter int unsigned PayloadWords = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en,
  input  logic [5:0]  word,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        irq_doorbell,
  output logic        irq_completion,
  output logic        busy
);

  localparam int unsigned PIdxW = (PayloadWords > 1) ? $clog2(PayloadWords) : 1;

  chan_state_e state;
  logic        err;
  logic        intr_en;
  logic [15:0] length;
  logic [31:0] payload [PayloadWords];
  logic [5:0]  pword;
  logic [PIdxW-1:0] pidx;
  logic        unused_pword;

  assign pword        = word - PAYLOAD_BASE;
  assign pidx         = pword[PIdxW-1:0];
  assign unused_pword = ^pword;

  // A release that fails the protocol check must win over an err clear in the same write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= FREE;
      err     <= 1'b0;
      intr_en <= 1'b0;
      length  <= '0;
      payload <= '{default: '0};
    end else if (wr_en) begin
      if (word >= PAYLOAD_BASE) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) payload[pidx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else if (wstrb[0]) begin
        case (word)
          STATUS: begin
            if (wdata[0] && state == DONE) state <= FREE;
            if (wdata[0] && state != DONE) err <= 1'b1;
            else if (wdata[3])             err <= 1'b0;
          end
          FLAGS:  intr_en <= wdata[0];
          LENGTH: length  <= wdata[15:0];
          DOORBELL: begin
            if (wdata[0]) begin
              if (state == FREE) state <= BUSY;
              else               err   <= 1'b1;
            end
          end
          COMPLETION: begin
            if (wdata[0]) begin
              if (state == BUSY) state <= DONE;
              else               err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      STATUS:     rdata = {28'b0, err, state == DONE, state == BUSY, state == FREE};
      FLAGS:      rdata = {31'b0, intr_en};
      LENGTH:     rdata = {16'b0, length};
      DOORBELL:   rdata = {31'b0, state == BUSY};
      COMPLETION: rdata = {31'b0, state == DONE};
      default:    if (word >= PAYLOAD_BASE) rdata = payload[pidx];
    endcase
  end

  assign irq_doorbell   = (state == BUSY);
  assign irq_completion = (state == DONE) && intr_en;
  assign busy           = (state != FREE);

endmodule

// File: rtl/scmi_mbox_multi.sv
// Multi-channel SCMI mailbox on a 32-bit reg bus: decodes channel/word,
// fans writes out to the channels and muxes read data back.
module scmi_mbox_multi
  import scmi_mbox_pkg::*;
#(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned PayloadWords = 16,
  parameter int unsigned AddrWidth    = 32,
  parameter type reg_req_t = scmi_mbox_pkg::scmi_reg_req_t,
  parameter type reg_rsp_t = scmi_mbox_pkg::scmi_reg_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  reg_req_t               reg_req_i,
  output reg_rsp_t               reg_rsp_o,
  output logic [NumChannels-1:0] irq_doorbell_o,
  output logic [NumChannels-1:0] irq_completion_o,
  output logic [NumChannels-1:0] chan_busy_o
);

  localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic [AddrWidth-1:0] addr;
  logic [ChanW-1:0]     chan_idx;
  logic [5:0]           word;
  logic [5:0]           pword;
  logic                 chan_ok;
  logic                 word_ok;
  logic                 hit;
  logic [31:0]          chan_rdata [NumChannels];
  logic                 unused_addr;

  assign addr        = reg_req_i.addr[AddrWidth-1:0];
  assign chan_idx    = addr[8 +: ChanW];
  assign word        = addr[7:2];
  assign pword       = word - PAYLOAD_BASE;
  assign unused_addr = ^addr[1:0];

  // Any set address bit above the channel field selects a non-existent channel.
  assign chan_ok = ((addr >> (8 + ChanW)) == '0) && (32'(chan_idx) < NumChannels);
  assign word_ok = (word <= COMPLETION) ||
                   ((word >= PAYLOAD_BASE) && (32'(pword) < PayloadWords));
  assign hit     = reg_req_i.valid && chan_ok && word_ok;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    scmi_mbox_channel #(
      .PayloadWords(PayloadWords)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .wr_en         (hit && reg_req_i.write && (32'(chan_idx) == c)),
      .word          (word),
      .wdata         (reg_req_i.wdata),
      .wstrb         (reg_req_i.wstrb),
      .rdata         (chan_rdata[c]),
      .irq_doorbell  (irq_doorbell_o[c]),
      .irq_completion(irq_completion_o[c]),
      .busy          (chan_busy_o[c])
    );
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_req_i.valid && !(chan_ok && word_ok);
    if (hit) reg_rsp_o.rdata = chan_rdata[chan_idx];
  end

endmodule

// File: doc/scmi_mbox_multi.md
Name: scmi_mbox_multi

Overview:
- Multi-channel SCMI mailbox on a 32-bit register bus. Generalises the single-channel doorbell/completion mailbox to NumChannels independent channels.
- Each channel has a shared payload memory, a FREE/BUSY/DONE channel state machine, per-channel doorbell and completion interrupts, and a polling mode.
- Sits behind an external AXI-to-reg bridge. Agents (application cores) raise doorbells; the platform (system controller) services them and signals completion.

Parameters:
- NumChannels, 2, number of independent mailbox channels (1..16).
- PayloadWords, 16, 32-bit payload words per channel (1..56).
- AddrWidth, 32, reg bus address width (at least 8 + clog2(NumChannels)).
- reg_req_t, logic, reg bus request type (valid, write, addr, wdata[31:0], wstrb[3:0]).
- reg_rsp_t, logic, reg bus response type (ready, rdata[31:0], error).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- reg_req_i  in  reg_req_t  register bus request.
- reg_rsp_o  out  reg_rsp_t  register bus response.
- irq_doorbell_o  out  NumChannels  level interrupt to the platform, one per channel.
- irq_completion_o  out  NumChannels  level interrupt to the agent, one per channel.
- chan_busy_o  out  NumChannels  state != FREE, per channel (debug/status).

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - All channels in FREE; FLAGS, LENGTH, ERR and payload cleared to 0.
  - All irq outputs 0; chan_busy_o 0.
  - reg_rsp_o: ready=1, error=0, rdata=0.
- Bus timing: ready is tied to 1. rdata and error are combinational in the request cycle. Write side effects land on the next clk_i edge. Reads are side-effect free.
- Address decode:
  - channel = addr[8 +: clog2(NumChannels)]; word = addr[7:2]. Each channel window is 0x100 bytes. addr[1:0] are ignored.
  - Invalid access: channel >= NumChannels, a reserved word, or payload word >= PayloadWords.
  - On an invalid access: error=1, rdata=0, no state change.
- Per-channel word map (offsets are byte addresses):
  - 0x00 STATUS: bit0 free (RO), bit1 busy (RO), bit2 done (RO), bit3 err (sticky). Writing bit0=1 releases the channel; writing bit3=1 clears err.
  - 0x04 FLAGS: bit0 intr_en (RW). When intr_en=1, DONE raises the completion irq.
  - 0x08 LENGTH: [15:0] RW, message length in bytes; [31:16] read 0.
  - 0x0C DOORBELL: writing bit0=1 rings the doorbell. Reads return {31'b0, state==BUSY}.
  - 0x10 COMPLETION: writing bit0=1 signals completion. Reads return {31'b0, state==DONE}.
  - 0x14–0x1C: reserved (invalid access).
  - 0x20 onward: payload words, RW, byte-granular per wstrb.
- Control registers (STATUS, FLAGS, LENGTH, DOORBELL, COMPLETION) act only when wstrb[0]=1. When wstrb[0]=0 the write is ignored, error=0.
- Channel FSM, states FREE, BUSY, DONE:
  - FREE, DOORBELL write with bit0=1 -> BUSY. irq_doorbell asserts on the following cycle.
  - BUSY, COMPLETION write with bit0=1 -> DONE. irq_doorbell deasserts; irq_completion = intr_en.
  - DONE, STATUS write with bit0=1 -> FREE. irq_completion deasserts.
  - A DOORBELL write in BUSY or DONE sets err and leaves the state unchanged.
  - A COMPLETION write in FREE or DONE sets err and leaves the state unchanged.
  - A release (STATUS bit0=1) in FREE or BUSY sets err and leaves the state unchanged.
  - Protocol errors never assert the bus error.
- irq_completion_o[c] = (state==DONE) && intr_en. Toggling intr_en while in DONE changes the irq in the next cycle.
- Combined STATUS write with bit0=1 and bit3=1: the err clear is applied first. A release attempted in the wrong state then sets err again, so err ends at 1.
- Payload and LENGTH are writable in any state; the protocol is not enforced on them.
- Asynchronous reset mid-transaction returns every channel to FREE and drops all irqs immediately.

Decomposition:
- Package scmi_mbox_pkg holds:
  - chan_state_e enum {FREE=2'd0, BUSY=2'd1, DONE=2'd2}.
  - Word offset constants: STATUS 0, FLAGS 1, LENGTH 2, DOORBELL 3, COMPLETION 4, PAYLOAD_BASE 8.
  - ChanWindowBytes = 256.
- Sub-module scmi_mbox_channel: one channel's FSM, flag registers and payload array, with a decoded per-channel write/read port.
- Top level: address decode, generate loop over channels, rdata mux, error generation.

Test Plan:
- Reset, then read ch0 STATUS -> 0x1; read ch1 LENGTH -> 0x0; all irqs 0.
- Ring and service ch1:
  - Write ch1 FLAGS=1, then DOORBELL=1 -> next cycle irq_doorbell_o=2'b10, STATUS=0x2.
  - Write COMPLETION=1 -> irq_doorbell_o=0, irq_completion_o=2'b10, STATUS=0x4.
  - Write STATUS=1 -> irqs 0, STATUS=0x1.
- Polling mode: ch0 with FLAGS=0, DOORBELL=1 then COMPLETION=1 -> irq_completion_o[0] stays 0; STATUS=0x4.
- Protocol error: DOORBELL=1 twice on ch0 -> state stays BUSY, STATUS=0xA. Write STATUS=0x8 -> STATUS=0x2.
- Payload strobes: write ch0 word 0x20 = 0xDEADBEEF with wstrb=4'b0101 over a 0 word -> read 0x00AD00EF.
- Decode errors: with NumChannels=2 and PayloadWords=16:
  - Access 0x200 -> error=1.
  - Access 0x60 -> error=1.
  - Access 0x14 -> error=1.
  - Access 0x5C -> error=0.
- Reset asserted while ch0 is BUSY -> irq_doorbell_o[0]=0 asynchronously; after release STATUS=0x1.
